// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings for the program counter and its neighbours
//   pc_op_e   : operation select driven by the decoder into pc_stack.op
//   pc_cond_e : branch condition select (used when PC_COND_BR_EN is defined)
//   EQ_BIT / GRT_BIT : ALU flag bit positions
package pc_pkg;

    typedef enum logic [2:0] {
        PC_OP_HOLD     = 3'b000,
        PC_OP_INC      = 3'b001,
        PC_OP_JREL     = 3'b010,
        PC_OP_JABS     = 3'b011,
        PC_OP_CALL_REL = 3'b100,
        PC_OP_CALL_ABS = 3'b101,
        PC_OP_RET      = 3'b110,
        PC_OP_CLEAR    = 3'b111
    } pc_op_e;

    typedef enum logic [1:0] {
        PC_COND_ALWAYS = 2'b00,
        PC_COND_EQ     = 2'b01,
        PC_COND_GRT    = 2'b10,
        PC_COND_NEQ    = 2'b11
    } pc_cond_e;

    localparam int EQ_BIT  = 0;
    localparam int GRT_BIT = 1;

endpackage

// File: rtl/ret_stack.sv
// ret_stack: return-address LIFO of DEPTH x WIDTH entries
//   clk, rst_n : clock, synchronous active-low reset (empties the stack)
//   clr_i      : synchronous soft clear (empties the stack)
//   push_i     : write din_i on top (ignored when full)
//   pop_i      : drop the top entry (ignored when empty)
//   top_o      : current top entry, meaningful only when not empty
//   depth_o    : entries held; full_o / empty_o decode it
module ret_stack #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 16,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] top_o,
    output logic [DW-1:0]    depth_o,
    output logic             full_o,
    output logic             empty_o
);

    // storage rounded up to a power of two so the index width is exact
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [2**IW];
    logic [DW-1:0]    depth_q, depth_d;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb depth_d = clr_i   ? '0 :
                          do_push ? depth_q + 1'b1 :
                          do_pop  ? depth_q - 1'b1 : depth_q;

    always_ff @(posedge clk) begin
        if (!rst_n) depth_q <= '0;
        else        depth_q <= depth_d;
    end

    // contents need no reset: nothing above depth_q is ever read
    always_ff @(posedge clk) begin
        if (do_push) mem_q[IW'(depth_q)] <= din_i;
    end

    assign top_o   = mem_q[IW'(depth_q - 1'b1)];
    assign depth_o = depth_q;
    assign full_o  = depth_q == DW'(DEPTH);
    assign empty_o = depth_q == '0;

endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with relative/absolute jumps, calls and a return stack
//   clk, rst_n  : clock, synchronous active-low reset
//   op          : pc_pkg::pc_op_e operation select
//   k           : signed relative offset, in instructions
//   target      : absolute destination (low alignment bits ignored)
//   flags, cond : only with PC_COND_BR_EN; gate jumps and calls on ALU flags
//   addr_instr  : registered fetch address
//   stack_depth, stack_full, stack_empty : return stack status
//   ovf_err, unf_err : sticky call-while-full / return-while-empty flags
module pc_stack
    import pc_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    OFFSET_WIDTH = 8,
    parameter int                    INSTR_BYTES  = 2,
    parameter int                    STACK_DEPTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR   = '0,
    localparam int                   DEPTH_W      = $clog2(STACK_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              op,
    input  logic [OFFSET_WIDTH-1:0] k,
    input  logic [ADDR_WIDTH-1:0]   target,
`ifdef PC_COND_BR_EN
    input  logic [7:0]              flags,
    input  logic [1:0]              cond,
`endif
    output logic [ADDR_WIDTH-1:0]   addr_instr,
    output logic [DEPTH_W-1:0]      stack_depth,
    output logic                    stack_full,
    output logic                    stack_empty,
    output logic                    ovf_err,
    output logic                    unf_err
);

    localparam int                    SHIFT = $clog2(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(INSTR_BYTES - 1);

    logic [ADDR_WIDTH-1:0]        addr_q, addr_d, seq_addr, rel_addr, abs_addr, top;
    logic signed [ADDR_WIDTH-1:0] k_ext;
    logic                         ovf_q, ovf_d, unf_q, unf_d;
    logic                         take, is_call, push, pop, clr, full, empty;

`ifdef PC_COND_BR_EN
    logic unused_flags;
    assign unused_flags = ^flags[7:2];
    assign take = cond == PC_COND_ALWAYS ||
                  (cond == PC_COND_EQ  &&  flags[EQ_BIT]) ||
                  (cond == PC_COND_GRT &&  flags[GRT_BIT]) ||
                  (cond == PC_COND_NEQ && !flags[EQ_BIT]);
`else
    assign take = 1'b1;
`endif

    // sign-extend first, then scale; modulo 2^ADDR_WIDTH arithmetic wraps silently
    assign k_ext    = ADDR_WIDTH'($signed(k));
    assign seq_addr = addr_q + STEP;
    assign rel_addr = addr_q + (k_ext << SHIFT);
    assign abs_addr = target & ALIGN;

    assign is_call = op == PC_OP_CALL_REL || op == PC_OP_CALL_ABS;
    assign push    = is_call && take && !full;
    assign pop     = op == PC_OP_RET;
    assign clr     = op == PC_OP_CLEAR;

    // an untaken jump or call degrades to a plain increment
    always_comb begin
        addr_d = addr_q;
        case (op)
            PC_OP_INC:      addr_d = seq_addr;
            PC_OP_JREL:     addr_d = take ? rel_addr : seq_addr;
            PC_OP_JABS:     addr_d = take ? abs_addr : seq_addr;
            PC_OP_CALL_REL: addr_d = !take ? seq_addr : full ? addr_q : rel_addr;
            PC_OP_CALL_ABS: addr_d = !take ? seq_addr : full ? addr_q : abs_addr;
            PC_OP_RET:      addr_d = empty ? addr_q : top;
            PC_OP_CLEAR:    addr_d = RESET_ADDR;
            default:        addr_d = addr_q;
        endcase
    end

    assign ovf_d = !clr && (ovf_q || (is_call && take && full));
    assign unf_d = !clr && (unf_q || (pop && empty));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= RESET_ADDR;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_ret_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (seq_addr),
        .top_o   (top),
        .depth_o (stack_depth),
        .full_o  (full),
        .empty_o (empty)
    );

    assign addr_instr  = addr_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: self-checking bench for pc_stack (default parameters)
module tb_pc_stack;
    import pc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [7:0]  k = 8'd0;
    logic [15:0] target = 16'd0;
`ifdef PC_COND_BR_EN
    logic [7:0]  flags = 8'd0;
    logic [1:0]  cond = 2'd0;
`endif
    logic [15:0] addr_instr;
    logic [3:0]  stack_depth;
    logic        stack_full, stack_empty, ovf_err, unf_err;

    pc_stack dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .k           (k),
        .target      (target),
`ifdef PC_COND_BR_EN
        .flags       (flags),
        .cond        (cond),
`endif
        .addr_instr  (addr_instr),
        .stack_depth (stack_depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .ovf_err     (ovf_err),
        .unf_err     (unf_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model: address as plain integer arithmetic, stack as a queue
    logic [15:0] m_addr = 16'd0;
    logic [15:0] m_stk[$];
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    function automatic logic model_take();
`ifdef PC_COND_BR_EN
        case (cond)
            2'd0:    return 1'b1;
            2'd1:    return flags[0];
            2'd2:    return flags[1];
            default: return !flags[0];
        endcase
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step();
        int          delta;
        logic [15:0] seq, rel, abs_t;
        logic        tk;
        delta = int'($signed(k)) * 2;
        seq   = 16'(int'(m_addr) + 2);
        rel   = 16'(int'(m_addr) + delta);
        abs_t = {target[15:1], 1'b0};
        tk    = model_take();
        if (!rst_n || op == 3'd7) begin
            m_addr = 16'd0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            case (op)
                3'd1: m_addr = seq;
                3'd2: m_addr = tk ? rel : seq;
                3'd3: m_addr = tk ? abs_t : seq;
                3'd4, 3'd5: begin
                    if (!tk) m_addr = seq;
                    else if (m_stk.size() == 8) m_ovf = 1'b1;
                    else begin
                        m_stk.push_back(seq);
                        m_addr = (op == 3'd4) ? rel : abs_t;
                    end
                end
                3'd6: begin
                    if (m_stk.size() == 0) m_unf = 1'b1;
                    else m_addr = m_stk.pop_back();
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] o, input logic [7:0] kk, input logic [15:0] t);
        rst_n  = r;
        op     = o;
        k      = kk;
        target = t;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [15:0] ea, input int ed, input logic eo, input logic eu);
        chk({name, ".addr"},  32'(addr_instr),  32'(ea));
        chk({name, ".depth"}, 32'(stack_depth), 32'(ed));
        chk({name, ".full"},  32'(stack_full),  32'(ed == 8));
        chk({name, ".empty"}, 32'(stack_empty), 32'(ed == 0));
        chk({name, ".ovf"},   32'(ovf_err),     32'(eo));
        chk({name, ".unf"},   32'(unf_err),     32'(eu));
    endtask

    task automatic chk_model(input string name);
        chk_all(name, m_addr, m_stk.size(), m_ovf, m_unf);
    endtask

    typedef struct {
        logic        r;
        logic [2:0]  o;
        logic [7:0]  kk;
        logic [15:0] t;
        logic [15:0] ea;
        int          ed;
        logic        eo;
        logic        eu;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [2:0] ro;
        vt.push_back('{1'b0, 3'd0, 8'h00, 16'h0000, 16'h0000, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd1, 8'h00, 16'h0000, 16'h0002, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd1, 8'h00, 16'h0000, 16'h0004, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd1, 8'h00, 16'h0000, 16'h0006, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd3, 8'h00, 16'h0010, 16'h0010, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd2, 8'hFD, 16'h0000, 16'h000A, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd3, 8'h00, 16'hFFFE, 16'hFFFE, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd1, 8'h00, 16'h0000, 16'h0000, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd2, 8'h80, 16'h0000, 16'hFF00, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd3, 8'h00, 16'h0123, 16'h0122, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd3, 8'h00, 16'h0020, 16'h0020, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd5, 8'h00, 16'h0101, 16'h0100, 1, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd0, 8'h00, 16'h0000, 16'h0100, 1, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd6, 8'h00, 16'h0000, 16'h0022, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd6, 8'h00, 16'h0000, 16'h0022, 0, 1'b0, 1'b1});
        vt.push_back('{1'b1, 3'd1, 8'h00, 16'h0000, 16'h0024, 0, 1'b0, 1'b1});
        vt.push_back('{1'b1, 3'd7, 8'h00, 16'h0000, 16'h0000, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd2, 8'h7F, 16'h0000, 16'h00FE, 0, 1'b0, 1'b0});
        vt.push_back('{1'b1, 3'd4, 8'hFF, 16'h0000, 16'h00FC, 1, 1'b0, 1'b0});
        vt.push_back('{1'b0, 3'd5, 8'h00, 16'h0400, 16'h0000, 0, 1'b0, 1'b0});

        foreach (vt[i]) begin
            drive(vt[i].r, vt[i].o, vt[i].kk, vt[i].t);
            chk_all($sformatf("vec%0d", i), vt[i].ea, vt[i].ed, vt[i].eo, vt[i].eu);
        end

        // nested calls to full, overflow, then unwind in reverse order
        drive(1'b1, 3'd7, 8'h00, 16'h0000);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 3'd4, 8'h04, 16'h0000);
            chk_all($sformatf("call%0d", i), 16'(8 * i), i, 1'b0, 1'b0);
        end
        drive(1'b1, 3'd4, 8'h04, 16'h0000);
        chk_all("call_ovf", 16'h0040, 8, 1'b1, 1'b0);
        for (int i = 8; i >= 1; i--) begin
            drive(1'b1, 3'd6, 8'h00, 16'h0000);
            chk_all($sformatf("ret%0d", i), 16'(8 * (i - 1) + 2), i - 1, 1'b1, 1'b0);
        end
        drive(1'b1, 3'd6, 8'h00, 16'h0000);
        chk_all("ret_unf", 16'h0002, 0, 1'b1, 1'b1);
        drive(1'b1, 3'd5, 8'h00, 16'h0040);
        chk_all("call_after_err", 16'h0040, 1, 1'b1, 1'b1);

        // reset in the middle of a call sequence
        drive(1'b1, 3'd7, 8'h00, 16'h0000);
        drive(1'b1, 3'd5, 8'h00, 16'h0200);
        drive(1'b1, 3'd5, 8'h00, 16'h0300);
        drive(1'b1, 3'd5, 8'h00, 16'h0400);
        chk_all("mid_depth3", 16'h0400, 3, 1'b0, 1'b0);
        drive(1'b0, 3'd5, 8'h00, 16'h0500);
        chk_all("mid_rst", 16'h0000, 0, 1'b0, 1'b0);
        drive(1'b1, 3'd6, 8'h00, 16'h0000);
        chk_all("rst_ret", 16'h0000, 0, 1'b0, 1'b1);

`ifdef PC_COND_BR_EN
        drive(1'b1, 3'd3, 8'h00, 16'h0030);
        cond = 2'd1;
        flags = 8'h00;
        drive(1'b1, 3'd2, 8'h05, 16'h0000);
        chk_all("cond_eq_not", 16'h0032, 0, 1'b0, 1'b1);
        flags = 8'h01;
        drive(1'b1, 3'd2, 8'h05, 16'h0000);
        chk_all("cond_eq_taken", 16'h003C, 0, 1'b0, 1'b1);
        cond = 2'd2;
        flags = 8'h00;
        drive(1'b1, 3'd5, 8'h00, 16'h0800);
        chk_all("cond_call_not", 16'h003E, 0, 1'b0, 1'b1);
        cond = 2'd0;
`endif

        // random traffic against the model
        drive(1'b1, 3'd7, 8'h00, 16'h0000);
        for (int n = 0; n < 3000; n++) begin
            ro = 3'($urandom_range(0, 7));
            if (ro == 3'd7 && $urandom_range(0, 7) != 0) ro = 3'd4;
`ifdef PC_COND_BR_EN
            cond  = 2'($urandom);
            flags = 8'($urandom);
`endif
            drive($urandom_range(0, 99) != 0, ro, 8'($urandom), 16'($urandom));
            chk_model($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
